// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Supports frame locking via req_last and aborts a transfer that never completes.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [8*N_REQ-1:0]   i_req_data,
  input  logic [N_REQ-1:0]     i_req_last,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_tx_start,
  output logic [7:0]           o_din,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done_tick,
  output logic [N_REQ-1:0]     o_grant,
  output logic                 o_busy,
  output logic                 o_timeout_err,
  output logic [1:0]           o_dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [7:0]         r_din;
  logic               r_last_q;
  logic [N_REQ-1:0]   r_grant;
  logic [CNT_W-1:0]   r_wd;

  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_found;
  logic [IDX_W-1:0]   w_acc_idx;
  logic [N_REQ-1:0]   w_acc_onehot;
  logic               w_accept;
  logic               w_timeout;
  logic               w_release;
  logic [IDX_W-1:0]   w_next_rr;
  logic [7:0]         w_data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_data_arr[g] = i_req_data[8*g +: 8];
  end

  // First valid requester at or above rr_ptr, wrapping at N_REQ.
  always_comb begin : rr_search
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    sum         = '0;
    idx         = '0;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      idx = sum[IDX_W-1:0];
      if (!w_win_found && i_req_valid[idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = idx;
      end
    end
  end

  // Handshake: a byte moves on a cycle where req_valid[i] & req_ready[i] are both 1.
  // Ready may depend on valid (IDLE picks among valid requesters) and is never
  // raised while the transmitter is active, in START/WAIT, or during reset.
  always_comb begin
    o_req_ready = '0;
    if (!i_reset && !i_tx_active) begin
      if (r_state == S_IDLE && w_win_found) o_req_ready[w_win_idx] = 1'b1;
      else if (r_state == S_LOCK)           o_req_ready[r_owner]   = i_req_valid[r_owner];
    end
  end

  assign w_accept  = |(o_req_ready & i_req_valid);
  assign w_acc_idx = (r_state == S_LOCK) ? r_owner : w_win_idx;

  always_comb begin
    w_acc_onehot            = '0;
    w_acc_onehot[w_acc_idx] = 1'b1;
  end

  assign w_timeout = (r_wd == CNT_W'(TIMEOUT - 1));
  assign w_next_rr = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
  // Ownership ends on the last byte's done, or on abort; done beats timeout.
  assign w_release = (r_state == S_WAIT) && (i_tx_done_tick ? r_last_q : w_timeout);

  always_comb begin
    w_next        = r_state;
    o_tx_start    = 1'b0;
    o_timeout_err = 1'b0;
    case (r_state)
      S_IDLE, S_LOCK: begin
        if (w_accept) w_next = S_START;
      end
      S_START: begin
        o_tx_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done_tick) begin
          w_next = r_last_q ? S_IDLE : S_LOCK;
        end else if (w_timeout) begin
          o_timeout_err = 1'b1;
          w_next        = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_din    <= '0;
      r_owner  <= '0;
      r_last_q <= 1'b1;
      r_grant  <= '0;
      r_wd     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_din    <= w_data_arr[w_acc_idx];
        r_last_q <= i_req_last[w_acc_idx];
        r_owner  <= w_acc_idx;
        r_grant  <= w_acc_onehot;
      end
      if (r_state == S_START)     r_wd <= '0;
      else if (r_state == S_WAIT) r_wd <= r_wd + CNT_W'(1);
      if (w_release) begin
        r_grant  <= '0;
        r_rr_ptr <= w_next_rr;
      end
    end
  end

  assign o_din       = r_din;
  assign o_grant     = r_grant;
  assign o_busy      = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a clocked transmitter model, directed sequences,
// a vector table for the IDLE pick, and randomized frames against a queue model.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int IW       = 2;
  localparam int DW       = 8 * N;
  localparam int CPB      = 4;
  localparam int TMO      = 60;
  localparam int CW       = 6;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int PERIOD   = BYTE_CYC + 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]  req_valid = '0;
  logic [DW-1:0] req_data  = '0;
  logic [N-1:0]  req_last  = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  grant;
  logic          tx_start;
  logic [7:0]    din;
  logic          busy;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  logic m_active      = 1'b0;
  logic m_done        = 1'b0;
  logic force_active  = 1'b0;
  logic force_done    = 1'b0;
  logic suppress_done = 1'b0;
  logic tx_active;
  logic tx_done;
  assign tx_active = m_active | force_active;
  assign tx_done   = m_done | force_done;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .i_req_last     (req_last),
    .o_req_ready    (req_ready),
    .o_tx_start     (tx_start),
    .o_din          (din),
    .i_tx_active    (tx_active),
    .i_tx_done_tick (tx_done),
    .o_grant        (grant),
    .o_busy         (busy),
    .o_timeout_err  (timeout_err),
    .o_dbg_state    (dbg_state)
  );

  // Transmitter model: no reset, samples tx_start when idle, busy 10 bit times.
  int m_cnt = 0;
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!m_active) begin
      if (tx_start) begin
        m_active <= 1'b1;
        m_cnt    <= 0;
      end
    end else if (m_cnt == BYTE_CYC - 1) begin
      m_active <= 1'b0;
      m_done   <= !suppress_done;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [8:0]  rq [N][$];       // per-requester {last, data}
  logic [11:0] exp_q[$];        // {idx, data} in expected service order
  logic [11:0] acc_q[$];        // {idx, data} as actually accepted
  logic [7:0]  start_q[$];      // din seen with each tx_start
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, last_acc_cyc = 0, acc_gap = 0;
  int bad_start = 0, bad_acc_active = 0, lock_bad = 0, din_drift = 0;
  bit lock_watch = 1'b0, have_din = 1'b0;
  logic [7:0] cur_din = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive queue heads at negedge, sample 1 time unit later.
  task automatic cycle(input bit fd);
    logic [N-1:0] acc;
    @(negedge clk);
    force_done = fd;
    for (int i = 0; i < N; i++) begin
      req_data = req_data & ~(DW'(8'hFF) << (8 * i));
      if (rq[i].size() > 0) begin
        req_valid[IW'(i)] = 1'b1;
        req_last[IW'(i)]  = rq[i][0][8];
        req_data          = req_data | (DW'(rq[i][0][7:0]) << (8 * i));
      end else begin
        req_valid[IW'(i)] = 1'b0;
        req_last[IW'(i)]  = 1'b0;
      end
    end
    #1;
    cyc++;
    if (tx_start) begin
      start_q.push_back(din);
      if (tx_active) bad_start++;
      cur_din  = din;
      have_din = 1'b1;
    end else if (have_din && din !== cur_din) begin
      din_drift++;
    end
    if (lock_watch && grant !== 4'b0010) lock_bad++;
    acc = req_valid & req_ready;
    if (acc != '0) begin
      check("ready_onehot", $countones(acc), 1);
      if (tx_active) bad_acc_active++;
      for (int i = 0; i < N; i++) begin
        if (acc[IW'(i)]) begin
          acc_q.push_back({4'(i), rq[i][0][7:0]});
          void'(rq[i].pop_front());
        end
      end
      acc_gap      = cyc - last_acc_cyc;
      last_acc_cyc = cyc;
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    rq[i].push_back({l, d});
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) rq[i].delete();
    reset = 1'b1;
    cycle(0);
    cycle(0);
    reset = 1'b0;
    for (int k = 0; k < 100 && tx_active; k++) cycle(0);
    acc_q.delete();
    start_q.delete();
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 200 && busy; k++) cycle(0);
    check({nm, "_idle"}, busy, 0);
  endtask

  // Wait for the next accept, then check it and the START cycle after it.
  task automatic serve_one(input int idx, input logic [7:0] data, input bit chk_gap, input string nm);
    int s = acc_q.size();
    int k = 0;
    while (acc_q.size() == s && k < 300) begin
      cycle(0);
      k++;
    end
    check({nm, "_accepted"}, acc_q.size(), s + 1);
    if (acc_q.size() > s) begin
      check({nm, "_idx"}, acc_q[s][11:8], idx);
      check({nm, "_data"}, acc_q[s][7:0], data);
      if (chk_gap) check({nm, "_gap"}, acc_gap, PERIOD);
    end
    cycle(0);
    check({nm, "_start"}, tx_start, 1);
    check({nm, "_din"}, din, data);
    check({nm, "_grant"}, grant, 1 << idx);
  endtask

  // Reference: whole frames in round-robin order from the pending queues.
  task automatic build_expected(input int rr0);
    logic [8:0] q [N][$];
    logic [8:0] b;
    int rr = rr0;
    int pend = 0;
    for (int i = 0; i < N; i++) begin
      q[i] = rq[i];
      pend += q[i].size();
    end
    exp_q.delete();
    while (pend > 0) begin
      for (int k = 0; k < N; k++) begin
        int idx = (rr + k) % N;
        if (q[idx].size() > 0) begin
          do begin
            b = q[idx].pop_front();
            pend--;
            exp_q.push_back({4'(idx), b[7:0]});
          end while (!b[8]);
          rr = (idx + 1) % N;
          break;
        end
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         act;
    logic [N-1:0] exp_ready;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    int k;
    int tot;
    int te_cnt;
    tbl[0] = '{4'b0001, 1'b0, 4'b0001};
    tbl[1] = '{4'b0110, 1'b0, 4'b0010};
    tbl[2] = '{4'b1000, 1'b0, 4'b1000};
    tbl[3] = '{4'b1111, 1'b0, 4'b0001};
    tbl[4] = '{4'b1100, 1'b0, 4'b0100};
    tbl[5] = '{4'b0000, 1'b0, 4'b0000};
    tbl[6] = '{4'b1111, 1'b1, 4'b0000};
    tbl[7] = '{4'b0010, 1'b1, 4'b0000};

    // ---- reset values ----
    do_reset();
    cycle(0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_din", din, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_state", dbg_state, 0);
    check("rst_ready", req_ready, 0);

    // ---- IDLE pick table, rr_ptr=0, no clock edge sees a valid ----
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      req_valid    = tbl[v].valid;
      force_active = tbl[v].act;
      #1;
      check($sformatf("tbl%0d_ready", v), req_ready, tbl[v].exp_ready);
      check($sformatf("tbl%0d_busy", v), busy, 0);
      req_valid    = '0;
      force_active = 1'b0;
    end

    // ---- single byte ----
    push(0, 8'h55, 1'b1);
    serve_one(0, 8'h55, 0, "single");
    cycle(0);
    check("single_start_pulse", tx_start, 0);
    wait_idle("single");
    check("single_grant_clear", grant, 0);
    check("single_sent", start_q.size() > 0 ? start_q[0] : 8'hxx, 8'h55);
    @(negedge clk);
    req_valid = 4'b0011;
    #1;
    check("single_next_rr", req_ready, 4'b0010);
    req_valid = '0;

    // ---- round robin from rr=0 ----
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 8'hA0 + 8'(i), 1'b1);
      push(i, 8'hA0 + 8'(i), 1'b1);
    end
    serve_one(0, 8'hA0, 0, "rr0_a");
    serve_one(1, 8'hA1, 1, "rr0_b");
    serve_one(2, 8'hA2, 1, "rr0_c");
    serve_one(3, 8'hA3, 1, "rr0_d");
    serve_one(0, 8'hA0, 1, "rr0_e");

    // ---- round robin from rr=2 ----
    do_reset();
    push(1, 8'h77, 1'b1);
    serve_one(1, 8'h77, 0, "rr2_pre");
    for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    serve_one(2, 8'hA2, 1, "rr2_a");
    serve_one(3, 8'hA3, 1, "rr2_b");
    serve_one(0, 8'hA0, 1, "rr2_c");
    serve_one(1, 8'hA1, 1, "rr2_d");

    // ---- frame lock ----
    do_reset();
    push(0, 8'h01, 1'b1);
    serve_one(0, 8'h01, 0, "lock_pre");
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    push(0, 8'h20, 1'b1);
    push(2, 8'h22, 1'b1);
    serve_one(1, 8'h10, 1, "lock_b0");
    lock_bad   = 0;
    lock_watch = 1'b1;
    serve_one(1, 8'h11, 1, "lock_b1");
    serve_one(1, 8'h12, 1, "lock_b2");
    lock_watch = 1'b0;
    check("lock_grant_held", lock_bad, 0);
    serve_one(2, 8'h22, 1, "lock_after");

    // ---- watchdog ----
    do_reset();
    suppress_done = 1'b1;
    push(0, 8'h5A, 1'b1);
    serve_one(0, 8'h5A, 0, "wd");
    k = 0;
    do begin
      cycle(0);
      k++;
    end while (!timeout_err && k < TMO + 10);
    check("wd_latency", k, TMO);
    cycle(0);
    check("wd_pulse_width", timeout_err, 0);
    check("wd_grant_clear", grant, 0);
    check("wd_busy", busy, 0);
    suppress_done = 1'b0;
    push(0, 8'h61, 1'b1);
    push(1, 8'h62, 1'b1);
    serve_one(1, 8'h62, 0, "wd_next");

    // ---- reset in the middle of a locked frame ----
    do_reset();
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    serve_one(1, 8'h10, 0, "mid_b0");
    serve_one(1, 8'h11, 1, "mid_b1");
    cycle(0);
    check("mid_in_wait", dbg_state, 2);
    push(0, 8'h33, 1'b1);
    bad_start      = 0;
    bad_acc_active = 0;
    reset          = 1'b1;
    cycle(0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_din", din, 0);
    check("mid_rst_state", dbg_state, 0);
    reset = 1'b0;
    serve_one(0, 8'h33, 0, "mid_after");
    check("mid_no_start_active", bad_start, 0);
    check("mid_no_accept_active", bad_acc_active, 0);

    // ---- done on the watchdog's final cycle ----
    do_reset();
    suppress_done = 1'b1;
    push(0, 8'h44, 1'b1);
    serve_one(0, 8'h44, 0, "sim");
    for (int j = 1; j < TMO; j++) cycle(0);
    cycle(1);
    check("sim_no_err", timeout_err, 0);
    check("sim_still_wait", dbg_state, 2);
    cycle(0);
    check("sim_busy", busy, 0);
    check("sim_grant", grant, 0);
    te_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      cycle(0);
      if (timeout_err) te_cnt++;
    end
    check("sim_no_late_err", te_cnt, 0);
    suppress_done = 1'b0;
    cycle(1);
    check("idle_done_state", dbg_state, 0);
    check("idle_done_grant", grant, 0);
    cycle(0);
    check("idle_done_busy", busy, 0);
    check("idle_done_start", tx_start, 0);

    // ---- randomized frames against the queue model ----
    do_reset();
    for (int f = 0; f < 12; f++) begin
      int r   = $urandom_range(0, N - 1);
      int len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) push(r, 8'($urandom), (b == len - 1));
    end
    build_expected(0);
    tot       = exp_q.size();
    din_drift = 0;
    have_din  = 1'b0;
    k = 0;
    while (acc_q.size() < tot && k < tot * (PERIOD + 5) + 100) begin
      cycle(0);
      k++;
    end
    wait_idle("rand");
    check("rand_count", acc_q.size(), tot);
    for (int j = 0; j < tot && j < acc_q.size(); j++)
      check($sformatf("rand_acc%0d", j), acc_q[j], exp_q[j]);
    check("rand_starts", start_q.size(), tot);
    for (int j = 0; j < tot && j < start_q.size(); j++)
      check($sformatf("rand_din%0d", j), start_q[j], exp_q[j][7:0]);
    check("rand_din_held", din_drift, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
